rowfdct: RTL and testbench
==========================

// Module: rowfdct
// PURPOSE
//  Forward 8-point 1-D DCT on one row of an 8x8 block, encoder-side counterpart of the row IDCT.
//  Takes level-shifted samples in natural order and produces 8 scaled integer DCT coefficients.
//  3-stage pipeline (butterfly / shift-add multiply / accumulate+round) with valid/ready on both sides.
//  Counts rows so the downstream column stage or quantizer sees a block boundary.
// PARAMETERS
//  IN_W   16  signed input sample width (2..16)
//  OUT_W  32  signed output coefficient width (>= IN_W+7)
//  SHIFT  8   rounding right-shift applied to each 2^11-scaled accumulation (1..12)
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          row x0..x7 valid
//  in_ready   out  1          block can accept a row this cycle
//  x0..x7     in   IN_W each  signed samples, x0 = leftmost pixel, natural order
//  out_valid  out  1          y0..y7 hold a result row
//  out_ready  in   1          downstream accepts the row
//  y0..y7     out  OUT_W each signed coefficients, y0 = DC, natural frequency order
//  out_row    out  3          row index of the presented result, 0..7
//  out_last   out  1          1 when out_row==7 (last row of block)
// BEHAVIOUR
//  Arithmetic: y[k] = (sum_{n=0..7} M[k][n]*x[n] + 2^(SHIFT-1)) >>> SHIFT, signed, 32-bit internal
//   (IN_W+15 bits needed, no overflow possible), then sign-extended/truncated to OUT_W.
//  M[0][n] = 2048 for all n. For k=1..7: m = ((2n+1)*k) mod 32; if m>16 then m=32-m;
//   if m>8 then M = -c[16-m] else M = +c[m]; c1..c7 = 2841,2676,2408,2048,1609,1108,565.
//  All constant products use shifts and adds only, no '*' operators. Rounding is floor of (acc+half).
//   Ties therefore round toward +inf.
//  Stage 1: s[n]=x[n]+x[7-n], d[n]=x[n]-x[7-n], n=0..3, registered.
//   Even y uses s only. Odd y uses d only.
//  Stage 2: shift-add constant products, registered. Stage 3: sums, +2^(SHIFT-1), >>>SHIFT, registered to y*.
//  Latency: 3 cycles from input handshake to out_valid, with no stall. Throughput 1 row/cycle.
//  Handshake: in accepted when in_valid&&in_ready. Output transfers when out_valid&&out_ready.
//  Stall: en = !out_valid || out_ready. in_ready = en (combinational).
//   With en=0, every pipeline register and valid bit holds.
//   y*, out_row and out_last stay stable while out_valid && !out_ready.
//  Full pipeline with out_ready=1: output transfer and new input accept happen in the same cycle.
//   No bubble is inserted.
//  Valid bits v1,v2,v3 advance when en=1. out_valid = v3. Bubbles propagate as v=0.
//   Data registers may update on bubbles. y* is don't-care when out_valid=0.
//  Row counter: in_row increments mod 8 on each input accept and travels with the data.
//   out_row is the travelled tag. out_last = (out_row==7). Wraps 7->0 with no gap.
//  Reset (any time, including mid-block or mid-stall): v1..v3=0, in_row=0.
//   y0..y7=0, out_row=0, out_last=0, out_valid=0, in_ready=1 in the first cycle after reset.
//   In-flight rows are discarded.
//  X/unknown on x* while in_valid=0 must not affect out_valid or the stored results.
// TESTING
//  1 DC: x0..x7=100 -> after 3 cycles y0=6400, y1..y7=0, out_row=0.
//  2 Impulse: x0=1000, others 0 -> y0..y7 = 8000,11098,10453,9406,8000,6285,4328,2207.
//  3 Negative rounding: all x=-1 -> y0=-64, y1..y7=0. Also random rows vs integer golden model.
//  4 Backpressure: stream 8 rows with out_ready toggling 1,0,0,1 -> no row lost or duplicated.
//    y* is stable during stalls. out_row runs 0..7 and out_last=1 only on the 8th output.
//  5 Back-to-back: 16 rows, in_valid=1 and out_ready=1 throughout -> 16 outputs on consecutive cycles.
//    out_row wraps 7->0. out_last pulses on outputs 8 and 16.
//  6 Reset mid-op: assert reset with 2 rows in flight and out_ready=0.
//    -> next cycle out_valid=0, y*=0, in_ready=1. Next accepted row emerges with out_row=0.

Source files
------------

// File: rtl/rowfdct_if.sv
// Row DCT stream bundle: input row handshake (in_valid/in_ready, x0..x7)
// and result row handshake (out_valid/out_ready, y0..y7, out_row, out_last).
interface rowfdct_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  x0, x1, x2, x3, x4, x5, x6, x7;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [2:0]              out_row;
    logic                    out_last;

    modport master (
        output in_valid, x0, x1, x2, x3, x4, x5, x6, x7,
        input  in_ready,
        input  out_valid, y0, y1, y2, y3, y4, y5, y6, y7,
        input  out_row, out_last,
        output out_ready
    );

    modport slave (
        input  in_valid, x0, x1, x2, x3, x4, x5, x6, x7,
        output in_ready,
        output out_valid, y0, y1, y2, y3, y4, y5, y6, y7,
        output out_row, out_last,
        input  out_ready
    );
endinterface

// File: rtl/rowfdct.sv
// Forward 8-point row DCT, 3-stage pipeline: butterfly, shift-add products,
// accumulate + round. Ports: clk, reset (sync, active-high), bus (slave).
module rowfdct #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 8
) (
    input  logic     clk,
    input  logic     reset,
    rowfdct_if.slave bus
);
    typedef logic signed [31:0] w_t;

    localparam w_t HALF = 32'sd1 <<< (SHIFT - 1);

    // Constant multipliers, c1..c7 of the 2^11-scaled cosine table.
    function automatic w_t mul_c1(w_t v);
        return (v <<< 11) + (v <<< 9) + (v <<< 8)
             + (v <<< 4) + (v <<< 3) + v;
    endfunction

    function automatic w_t mul_c2(w_t v);
        return (v <<< 11) + (v <<< 9) + (v <<< 6)
             + (v <<< 5) + (v <<< 4) + (v <<< 2);
    endfunction

    function automatic w_t mul_c3(w_t v);
        return (v <<< 11) + (v <<< 8) + (v <<< 6)
             + (v <<< 5) + (v <<< 3);
    endfunction

    function automatic w_t mul_c4(w_t v);
        return v <<< 11;
    endfunction

    function automatic w_t mul_c5(w_t v);
        return (v <<< 10) + (v <<< 9) + (v <<< 6)
             + (v <<< 3) + v;
    endfunction

    function automatic w_t mul_c6(w_t v);
        return (v <<< 10) + (v <<< 6) + (v <<< 4)
             + (v <<< 2);
    endfunction

    function automatic w_t mul_c7(w_t v);
        return (v <<< 9) + (v <<< 5) + (v <<< 4)
             + (v <<< 2) + v;
    endfunction

    // Floor of (acc + half) >> SHIFT, then fit to OUT_W.
    function automatic logic signed [OUT_W-1:0] rnd(w_t a);
        w_t t;
        t = (a + HALF) >>> SHIFT;
        return OUT_W'(t);
    endfunction

    // Pipeline control
    logic       en;
    logic       v1, v2, v3;
    logic [2:0] in_row, r1, r2;

    assign en           = !v3 || bus.out_ready;
    assign bus.in_ready = en;

    // Input row, sign-extended to the internal width
    w_t xa [8];

    assign xa[0] = 32'(bus.x0);
    assign xa[1] = 32'(bus.x1);
    assign xa[2] = 32'(bus.x2);
    assign xa[3] = 32'(bus.x3);
    assign xa[4] = 32'(bus.x4);
    assign xa[5] = 32'(bus.x5);
    assign xa[6] = 32'(bus.x6);
    assign xa[7] = 32'(bus.x7);

    // Stage 1: butterfly
    w_t s [4];
    w_t d [4];

    // Stage 2: products. Even half works on s, odd half on d.
    w_t p_dc, p_y4;
    w_t p_c2a, p_c6a, p_c2b, p_c6b;
    w_t p1 [4];
    w_t p3 [4];
    w_t p5 [4];
    w_t p7 [4];

    // Stage 3: results
    logic signed [OUT_W-1:0] y [8];
    logic [2:0]              row_q;
    logic                    last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            in_row <= 3'd0;
            r1     <= 3'd0;
            r2     <= 3'd0;
            row_q  <= 3'd0;
            last_q <= 1'b0;
        end else if (en) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            v3 <= v2;
            if (bus.in_valid) begin
                in_row <= in_row + 3'd1;
                r1     <= in_row;
            end
            if (v1) begin
                r2 <= r1;
            end
            if (v2) begin
                row_q  <= r2;
                last_q <= (r2 == 3'd7);
            end
        end
    end

    // Data registers only load on real rows, so idle X on x* never
    // reaches stored state.
    always_ff @(posedge clk) begin
        if (en && bus.in_valid) begin
            for (int n = 0; n < 4; n++) begin
                s[n] <= xa[n] + xa[7-n];
                d[n] <= xa[n] - xa[7-n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && v1) begin
            p_dc  <= mul_c4(s[0] + s[1] + s[2] + s[3]);
            p_y4  <= mul_c4(s[0] - s[1] - s[2] + s[3]);
            p_c2a <= mul_c2(s[0] - s[3]);
            p_c6a <= mul_c6(s[0] - s[3]);
            p_c2b <= mul_c2(s[1] - s[2]);
            p_c6b <= mul_c6(s[1] - s[2]);
            for (int n = 0; n < 4; n++) begin
                p1[n] <= mul_c1(d[n]);
                p3[n] <= mul_c3(d[n]);
                p5[n] <= mul_c5(d[n]);
                p7[n] <= mul_c7(d[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                y[k] <= '0;
            end
        end else if (en && v2) begin
            y[0] <= rnd(p_dc);
            y[1] <= rnd(p1[0] + p3[1] + p5[2] + p7[3]);
            y[2] <= rnd(p_c2a + p_c6b);
            y[3] <= rnd(p3[0] - p7[1] - p1[2] - p5[3]);
            y[4] <= rnd(p_y4);
            y[5] <= rnd(p5[0] - p1[1] + p7[2] + p3[3]);
            y[6] <= rnd(p_c6a - p_c2b);
            y[7] <= rnd(p7[0] - p5[1] + p3[2] - p1[3]);
        end
    end

    assign bus.out_valid = v3;
    assign bus.out_row   = row_q;
    assign bus.out_last  = last_q;
    assign bus.y0        = y[0];
    assign bus.y1        = y[1];
    assign bus.y2        = y[2];
    assign bus.y3        = y[3];
    assign bus.y4        = y[4];
    assign bus.y5        = y[5];
    assign bus.y6        = y[6];
    assign bus.y7        = y[7];
endmodule

// File: tb/tb_rowfdct.sv
// Scoreboard bench for rowfdct: directed rows plus a small golden model,
// backpressure, back-to-back streaming and reset while rows are in flight.
module tb_rowfdct;
    typedef int vec8_t [8];

    typedef struct packed {
        logic [7:0][31:0] y;
        logic [2:0]       row;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   phase = 0;
    int   tb_row = 0;
    bit   consec = 1'b0;
    bit   consec_started = 1'b0;
    int   last_xfer = 0;
    bit   prev_stall = 1'b0;
    logic [7:0][31:0] held_y;
    logic [2:0]       held_row;
    exp_t sb [$];

    rowfdct_if #(.IN_W(16), .OUT_W(32)) bus ();

    rowfdct #(.IN_W(16), .OUT_W(32), .SHIFT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0][31:0] get_y();
        return {bus.y7, bus.y6, bus.y5, bus.y4,
                bus.y3, bus.y2, bus.y1, bus.y0};
    endfunction

    function automatic int coef(int k, int n);
        int c [8];
        int m;
        c = '{0, 2841, 2676, 2408, 2048, 1609, 1108, 565};
        if (k == 0) return 2048;
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        if (m > 8) return -c[16 - m];
        return c[m];
    endfunction

    function automatic vec8_t model(vec8_t x);
        vec8_t r;
        longint acc;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) acc += longint'(coef(k, n)) * x[n];
            r[k] = int'((acc + 128) >>> 8);
        end
        return r;
    endfunction

    task automatic set_x(input vec8_t xv);
        bus.x0 = 16'(xv[0]);
        bus.x1 = 16'(xv[1]);
        bus.x2 = 16'(xv[2]);
        bus.x3 = 16'(xv[3]);
        bus.x4 = 16'(xv[4]);
        bus.x5 = 16'(xv[5]);
        bus.x6 = 16'(xv[6]);
        bus.x7 = 16'(xv[7]);
    endtask

    task automatic idle_x();
        bus.in_valid = 1'b0;
        bus.x0 = 'x; bus.x1 = 'x; bus.x2 = 'x; bus.x3 = 'x;
        bus.x4 = 'x; bus.x5 = 'x; bus.x6 = 'x; bus.x7 = 'x;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_row(input vec8_t xv, input vec8_t ev);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        set_x(xv);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) begin
                for (int k = 0; k < 8; k++) e.y[k] = ev[k];
                e.row = 3'(tb_row);
                tb_row = (tb_row + 1) % 8;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        idle_x();
    endtask

    task automatic send_rand();
        vec8_t xv;
        for (int n = 0; n < 8; n++) xv[n] = int'($urandom_range(4095)) - 2048;
        send_row(xv, model(xv));
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d rows pending, required 0",
                     sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_x();
        sb.delete();
        tb_row = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    bus.out_ready = (phase == 0 || phase == 3);
                    phase = (phase + 1) % 4;
                end
                2: bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        logic [7:0][31:0] cy;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                consec_started = 1'b0;
            end else begin
                cy = get_y();
                if (prev_stall) begin
                    checks++;
                    if (cy != held_y || bus.out_row != held_row) begin
                        errors++;
                        $display("FAIL stall_hold: y=%h row=%0d, required y=%h row=%0d",
                                 cy, bus.out_row, held_y, held_row);
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                held_y = cy;
                held_row = bus.out_row;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: row=%0d, required no output",
                                 bus.out_row);
                    end else begin
                        e = sb.pop_front();
                        for (int k = 0; k < 8; k++) begin
                            checks++;
                            if (cy[k] != e.y[k]) begin
                                errors++;
                                $display("FAIL y%0d: got %0d, required %0d",
                                         k, $signed(cy[k]), $signed(e.y[k]));
                            end
                        end
                        checks++;
                        if (bus.out_row != e.row) begin
                            errors++;
                            $display("FAIL out_row: got %0d, required %0d",
                                     bus.out_row, e.row);
                        end
                        checks++;
                        if (bus.out_last != (e.row == 3'd7)) begin
                            errors++;
                            $display("FAIL out_last: got %0d, required %0d",
                                     bus.out_last, e.row == 3'd7);
                        end
                        if (consec) begin
                            if (consec_started) begin
                                checks++;
                                if (cyc - last_xfer != 1) begin
                                    errors++;
                                    $display("FAIL consecutive: gap %0d cycles, required 1",
                                             cyc - last_xfer);
                                end
                            end
                            consec_started = 1'b1;
                            last_xfer = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin
        vec8_t xv;
        vec8_t ev;
        reset = 1'b1;
        idle_x();
        do_reset();

        // Reset state
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_row !== 3'd0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_tag: row=%0d last=%b, required 0 0",
                     bus.out_row, bus.out_last);
        end
        checks++;
        if (get_y() !== '0) begin
            errors++;
            $display("FAIL reset_y: got %h, required 0", get_y());
        end
        @(posedge clk);
        #1;

        // DC
        xv = '{100, 100, 100, 100, 100, 100, 100, 100};
        ev = '{6400, 0, 0, 0, 0, 0, 0, 0};
        send_row(xv, ev);
        // Impulse
        xv = '{1000, 0, 0, 0, 0, 0, 0, 0};
        ev = '{8000, 11098, 10453, 9406, 8000, 6285, 4328, 2207};
        send_row(xv, ev);
        // Negative rounding
        xv = '{-1, -1, -1, -1, -1, -1, -1, -1};
        ev = '{-64, 0, 0, 0, 0, 0, 0, 0};
        send_row(xv, ev);
        // Impulse at the far end, negative
        xv = '{0, 0, 0, 0, 0, 0, 0, -1000};
        ev = '{-8000, 11098, -10453, 9406, -8000, 6285, -4328, 2207};
        send_row(xv, ev);
        for (int i = 0; i < 4; i++) send_rand();
        wait_drain();

        // Backpressure
        do_reset();
        rdy_mode = 1;
        phase = 0;
        for (int i = 0; i < 8; i++) send_rand();
        wait_drain();
        rdy_mode = 0;

        // Back-to-back
        do_reset();
        @(posedge clk);
        #1;
        consec = 1'b1;
        for (int i = 0; i < 16; i++) send_rand();
        wait_drain();
        consec = 1'b0;

        // Reset with rows in flight
        do_reset();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_rand();
        send_rand();
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        tb_row = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || get_y() !== '0) begin
            errors++;
            $display("FAIL midreset_out: valid=%b y=%h, required 0 0",
                     bus.out_valid, get_y());
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        xv = '{100, 100, 100, 100, 100, 100, 100, 100};
        ev = '{6400, 0, 0, 0, 0, 0, 0, 0};
        send_row(xv, ev);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
